adder_share_arbiter: RTL



---
 rtl/adder_arb_pkg.sv | 6 +
 rtl/adder_share_arbiter_rr_picker.sv | 28 ++
 rtl/adder_share_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: FSM state encoding and default widths shared by the adder share arbiter.
package adder_arb_pkg;
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   localparam int DEF_WIDTH = 6;
   localparam int DEF_RES_W = 8;
endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search from i_ptr upward, wrapping modulo NREQ.
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);
   int             w_j;
   logic [IDW-1:0] w_pos;
   // Walk offsets from farthest to nearest so the closest requester wins.
   always_comb begin
      w_j   = 0;
      w_pos = '0;
      o_idx = '0;
      o_any = |i_req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_j   = int'(i_ptr) + k;
         w_j   = (w_j >= NREQ) ? w_j - NREQ : w_j;
         w_pos = IDW'(w_j);
         o_idx = i_req[w_pos] ? w_pos : o_idx;
      end
      o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
   end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin time-sharing of one adder between NREQ requesters,
// registering the granted operands and returning the tagged result on a response channel.
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEF_WIDTH,
   parameter int RES_W = WIDTH + 2,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   output logic                  add_cin,
   input  logic [RES_W-1:0]      add_res,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [RES_W-1:0]      rsp_data,
   output logic                  busy
);
   state_t           r_state, w_next;
   logic [IDW-1:0]   r_ptr, w_idx;
   logic [NREQ-1:0]  w_gnt;
   logic             w_any;
   logic [WIDTH-1:0] w_a [NREQ];
   logic [WIDTH-1:0] w_b [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_a[g] = req_a[g*WIDTH +: WIDTH];
      assign w_b[g] = req_b[g*WIDTH +: WIDTH];
   end

   rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign req_ready = (r_state == IDLE) ? w_gnt : '0;
   assign busy      = r_state != IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_any ? CALC : IDLE;
         CALC:    w_next = RESP;
         RESP:    w_next = rsp_ready ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end

   // Operands stay on the adder after completion; only a new grant replaces them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr     <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         if (r_state == IDLE && w_any) begin
            add_a   <= w_a[w_idx];
            add_b   <= w_b[w_idx];
            add_cin <= req_cin[w_idx];
            rsp_id  <= w_idx;
            r_ptr   <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
         end
         if (r_state == CALC) begin
            rsp_data  <= add_res;
            rsp_valid <= 1'b1;
         end
         if (r_state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule
